carregador_instrucao_mem: RTL

- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory's word-indexed write port.
- Holds the CPU stalled while loading and flags completion or error.
- Sits between the external loader link (serial/byte bridge) and the instruction memory array.

---
 rtl/carregador_instrucao_mem.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/carregador_instrucao_mem.sv
// Instruction-memory loader.
// Receives a program as a byte stream: a 16-bit little-endian word count,
// then the words themselves, each as 4 little-endian bytes. Every complete
// word is written to the instruction memory's write port. The CPU is held
// stalled while a load is in progress, and also after a rejected load.
module carregador_instrucao_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       word_asm;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              xfer;

    // The loader only listens while it is collecting header or data bytes.
    assign byte_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
    assign xfer       = byte_valid && byte_ready;

    // Each byte lane takes the incoming byte when it is the lane being filled.
    // word_asm already includes the byte arriving this cycle, so the 4th byte
    // can be written out without an extra cycle of delay.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_asm[8*gi +: 8] =
                (xfer && (state_q == S_DATA) && (byte_idx_q == 2'(gi))) ? byte_in : word_q[8*gi +: 8];
        end
    endgenerate

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_asm;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_HDR_LO;
                    cpu_hold_d     = 1'b1;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    byte_idx_d     = 2'd0;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = {count_q[15:8], byte_in};
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    count_d = {byte_in, count_q[7:0]};
                    if (count_d == 16'd0) begin
                        // Empty program: nothing to write, release the CPU.
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (32'(count_d) > 32'(DEPTH)) begin
                        // Program larger than the memory; keep the CPU held.
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d    = S_WRITE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = words_loaded_q[ADDR_W-1:0];
                        mem_data_d = word_asm;
                    end
                end
            end
            S_WRITE: begin
                words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
                if (32'(words_loaded_q) + 32'd1 == 32'(count_q)) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            cpu_hold_q     <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
